// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: turns the single-cycle D-mem port into a valid/ready bus access with stall, timeout and fault reporting
module dmem_bus_bridge #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read_m,
   input  logic        mem_write_m,
   input  logic        kill_m,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic [31:0] d_rdata,
   output logic        stall_m,
   output logic        access_fault,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic [31:0] bus_addr,
   output logic        bus_we,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wstrb,
   input  logic        bus_resp_valid,
   input  logic [31:0] bus_rdata,
   input  logic        bus_err
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   localparam logic [1:0] DONE = 2'd3;
   // counter value seen in the last REQ/RESP cycle allowed before forcing a fault
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      addr_q, wdata_q, rdata_q;
   logic [3:0]       wstrb_q;
   logic             we_q, err_q;
   logic             op, expired;
   assign op      = (mem_read_m | mem_write_m) & ~kill_m;
   assign expired = (TIMEOUT_CYCLES != 0) && (cnt >= LAST);
   // access state machine; handshake and response take priority over a coincident timeout
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (op) begin
               state   <= REQ;
               cnt     <= '0;
               addr_q  <= d_addr;
               wdata_q <= d_wdata;
               wstrb_q <= d_wstrb;
               we_q    <= mem_write_m;
            end
            REQ: begin
               cnt <= cnt + CNT_W'(1);
               if (bus_req_ready) state <= RESP;
               else if (expired) begin
                  state   <= DONE;
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end
            end
            RESP: begin
               cnt <= cnt + CNT_W'(1);
               if (bus_resp_valid) begin
                  state <= DONE;
                  err_q <= bus_err;
                  if (!we_q) rdata_q <= bus_rdata;
               end else if (expired) begin
                  state   <= DONE;
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
   // outputs are decoded from registered state only, except the IDLE stall which must react to a new op at once
   always_comb begin
      stall_m       = (state == IDLE) ? op : (state != DONE);
      access_fault  = (state == DONE) & err_q;
      bus_req_valid = (state == REQ);
      bus_addr      = addr_q & ~32'h3;
      bus_we        = we_q;
      bus_wdata     = wdata_q;
      bus_wstrb     = we_q ? wstrb_q : 4'b0000;
      d_rdata       = rdata_q;
   end
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge: table-driven accesses against a scripted bus responder, expected results queued per access
module tb_dmem_bus_bridge;
   logic        clk = 1'b0;
   logic        rst_n, mem_read_m, mem_write_m, kill_m;
   logic [31:0] d_addr, d_wdata, d_rdata, bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  d_wstrb, bus_wstrb;
   logic        stall_m, access_fault, bus_req_valid, bus_req_ready, bus_we, bus_resp_valid, bus_err;
   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        we;
      logic        kill;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          rdly;
      int          rlat;
      logic [31:0] rdata;
      logic        err;
      logic [31:0] exp_rdata;
      logic        exp_fault;
      int          exp_stalls;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          stalls;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[10];

   dmem_bus_bridge #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .kill_m(kill_m),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_rdata(d_rdata),
      .stall_m(stall_m), .access_fault(access_fault),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
      .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
      .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // drive one access from the table, act as the bus, and compare at the DONE cycle
   task automatic run_vec(input int idx, input vec_t v);
      int   nreq, nresp, stalls;
      bit   done;
      exp_t e;
      mem_read_m  = !v.we;
      mem_write_m = v.we;
      kill_m      = v.kill;
      d_addr      = v.addr;
      d_wdata     = v.wdata;
      d_wstrb     = v.wstrb;
      #1;
      chk($sformatf("v%0d issue_stall", idx), {31'b0, stall_m}, {31'b0, !v.kill});
      if (v.kill) begin
         @(negedge clk);
         chk($sformatf("v%0d kill_req_valid", idx), {31'b0, bus_req_valid}, 0);
         chk($sformatf("v%0d kill_stall", idx), {31'b0, stall_m}, 0);
         mem_read_m = 1'b0; mem_write_m = 1'b0; kill_m = 1'b0;
         return;
      end
      sb.push_back('{rdata: v.exp_rdata, fault: v.exp_fault, stalls: v.exp_stalls});
      stalls = 1; nreq = 0; nresp = 0; done = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         bus_req_ready  = 1'b0;
         bus_resp_valid = 1'b0;
         bus_err        = 1'b0;
         d_addr  = ~v.addr;
         d_wdata = ~v.wdata;
         d_wstrb = ~v.wstrb;
         kill_m  = 1'b1;
         if (!stall_m) begin
            done = 1'b1;
            break;
         end
         stalls++;
         if (bus_req_valid) begin
            nreq++;
            chk($sformatf("v%0d bus_addr", idx), bus_addr, v.addr & ~32'h3);
            chk($sformatf("v%0d bus_we", idx), {31'b0, bus_we}, {31'b0, v.we});
            chk($sformatf("v%0d bus_wdata", idx), bus_wdata, v.wdata);
            chk($sformatf("v%0d bus_wstrb", idx), {28'b0, bus_wstrb}, {28'b0, v.we ? v.wstrb : 4'b0});
            bus_req_ready = (nreq == v.rdly + 1);
         end else begin
            nresp++;
            if (nresp == v.rlat) begin
               bus_resp_valid = 1'b1;
               bus_rdata      = v.we ? 32'h5555_5555 : v.rdata;
               bus_err        = v.err;
            end
         end
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL v%0d done_timeout: no DONE cycle within 100 cycles", idx);
      end
      e = sb.pop_front();
      chk($sformatf("v%0d d_rdata", idx), d_rdata, e.rdata);
      chk($sformatf("v%0d access_fault", idx), {31'b0, access_fault}, {31'b0, e.fault});
      chk($sformatf("v%0d stall_cycles", idx), stalls, e.stalls);
      chk($sformatf("v%0d done_req_valid", idx), {31'b0, bus_req_valid}, 0);
      mem_read_m = 1'b0; mem_write_m = 1'b0; kill_m = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d idle_fault", idx), {31'b0, access_fault}, 0);
      chk($sformatf("v%0d idle_stall", idx), {31'b0, stall_m}, 0);
      chk($sformatf("v%0d idle_rdata", idx), d_rdata, e.rdata);
   endtask

   initial begin
      // we kill addr wdata wstrb rdly rlat rdata err | exp_rdata exp_fault exp_stalls (timeout = 8)
      tbl[0] = '{0, 0, 32'h0000_1004, 32'h0, 4'h0, 0, 1, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 3};
      tbl[1] = '{1, 0, 32'h0000_2002, 32'hABCD_0000, 4'hC, 3, 1, 32'h0, 0, 32'hDEAD_BEEF, 0, 6};
      tbl[2] = '{0, 1, 32'h0000_3000, 32'h0, 4'h0, 0, 1, 32'h0, 0, 32'h0, 0, 0};
      tbl[3] = '{0, 0, 32'h0000_4000, 32'h0, 4'h0, 99, 1, 32'h1111_1111, 0, 32'h0, 1, 9};
      tbl[4] = '{0, 0, 32'h0000_5004, 32'h0, 4'h0, 0, 2, 32'h1234_5678, 1, 32'h1234_5678, 1, 4};
      tbl[5] = '{0, 0, 32'h0000_3008, 32'h0, 4'h0, 1, 2, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 0, 5};
      tbl[6] = '{1, 0, 32'h0000_6001, 32'h0000_00AA, 4'h1, 0, 1, 32'h0, 1, 32'hCAFE_F00D, 1, 3};
      tbl[7] = '{0, 0, 32'h0000_7000, 32'h0, 4'h0, 2, 7, 32'h2222_2222, 0, 32'h0, 1, 9};
      tbl[8] = '{0, 0, 32'h0000_8000, 32'h0, 4'h0, 2, 5, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 0, 9};
      tbl[9] = '{1, 0, 32'h0000_0040, 32'h0000_BEEF, 4'h3, 0, 3, 32'h0, 0, 32'h0BAD_F00D, 0, 5};
      rst_n = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0; kill_m = 1'b0;
      d_addr = '0; d_wdata = '0; d_wstrb = '0;
      bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst d_rdata", d_rdata, 0);
      chk("rst req_valid", {31'b0, bus_req_valid}, 0);
      chk("rst stall", {31'b0, stall_m}, 0);
      chk("rst fault", {31'b0, access_fault}, 0);
      chk("rst bus_addr", bus_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);
      foreach (tbl[i]) run_vec(i, tbl[i]);
      // reset while waiting in RESP abandons the access and a late response is ignored
      mem_read_m = 1'b1; d_addr = 32'h0000_0500;
      @(negedge clk);
      chk("rr req_valid", {31'b0, bus_req_valid}, 1);
      bus_req_ready = 1'b1;
      @(negedge clk);
      bus_req_ready = 1'b0;
      chk("rr in_resp_stall", {31'b0, stall_m}, 1);
      rst_n = 1'b0; mem_read_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rr stall", {31'b0, stall_m}, 0);
      chk("rr d_rdata", d_rdata, 0);
      chk("rr req_valid_after", {31'b0, bus_req_valid}, 0);
      bus_resp_valid = 1'b1; bus_rdata = 32'hFFFF_FFFF; bus_err = 1'b1;
      @(negedge clk);
      bus_resp_valid = 1'b0; bus_err = 1'b0;
      chk("rr late_rdata", d_rdata, 0);
      chk("rr late_stall", {31'b0, stall_m}, 0);
      chk("rr late_fault", {31'b0, access_fault}, 0);
      @(negedge clk);
      chk("rr idle_fault", {31'b0, access_fault}, 0);
      chk("rr idle_req_valid", {31'b0, bus_req_valid}, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
